// File: rtl/insn_encoder_loader_pkg.sv
// Shared instruction-word layout, opcode/funct constants and loader types
// for the producer side of the CPU instruction-format contract.
package insn_encoder_loader_pkg;

  localparam int OP_POS    = 26;
  localparam int RS_POS    = 21;
  localparam int RT_POS    = 16;
  localparam int RD_POS    = 11;
  localparam int SHIFT_POS = 6;
  localparam int FUNCT_POS = 0;

  localparam logic [5:0] OP_CODE_RTYPE = 6'd0;
  localparam logic [5:0] OP_CODE_BEQ   = 6'd4;
  localparam logic [5:0] OP_CODE_BNE   = 6'd5;
  localparam logic [5:0] OP_CODE_ADDI  = 6'd8;
  localparam logic [5:0] OP_CODE_ANDI  = 6'd12;
  localparam logic [5:0] OP_CODE_ORI   = 6'd13;
  localparam logic [5:0] OP_CODE_LW    = 6'd35;
  localparam logic [5:0] OP_CODE_SW    = 6'd43;

  localparam logic [5:0] FUNCT_CODE_SLL = 6'd0;
  localparam logic [5:0] FUNCT_CODE_SRL = 6'd2;
  localparam logic [5:0] FUNCT_CODE_ADD = 6'd32;
  localparam logic [5:0] FUNCT_CODE_SUB = 6'd34;
  localparam logic [5:0] FUNCT_CODE_AND = 6'd36;
  localparam logic [5:0] FUNCT_CODE_OR  = 6'd37;
  localparam logic [5:0] FUNCT_CODE_SLT = 6'd42;

  typedef enum logic [1:0] {
    LOAD_ERR_NONE  = 2'd0,
    LOAD_ERR_OP    = 2'd1,
    LOAD_ERR_FUNCT = 2'd2,
    LOAD_ERR_RANGE = 2'd3
  } LoadErrCode;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } LoadState;

  function automatic logic IS_SUPPORTED_OP(input logic [5:0] op);
    case (op)
      OP_CODE_RTYPE, OP_CODE_LW, OP_CODE_SW, OP_CODE_ADDI,
      OP_CODE_ANDI, OP_CODE_ORI, OP_CODE_BEQ, OP_CODE_BNE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic IS_SUPPORTED_FUNCT(input logic [5:0] funct);
    case (funct)
      FUNCT_CODE_SLL, FUNCT_CODE_SRL, FUNCT_CODE_ADD, FUNCT_CODE_SUB,
      FUNCT_CODE_AND, FUNCT_CODE_OR, FUNCT_CODE_SLT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/insn_encoder_loader_packer.sv
// Combinational packer: turns one field bundle into a 32-bit instruction word
// and flags opcodes/functs the decoder does not understand.
module insn_packer
  import insn_encoder_loader_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [3:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] constVal,
  output logic [31:0] word,
  output logic        bad_op,
  output logic        bad_funct
);

  logic isRType;
  assign isRType = (op == OP_CODE_RTYPE);

  always_comb begin
    word = '0;
    word[OP_POS +: 6] = op;
    word[RS_POS +: 5] = rs;
    word[RT_POS +: 5] = rt;
    if (isRType) begin
      // bit 10 stays zero: the shift field is only four bits wide here
      word[RD_POS +: 5]    = rd;
      word[SHIFT_POS +: 4] = shamt;
      word[FUNCT_POS +: 6] = funct;
    end else begin
      word[15:0] = constVal;
    end
  end

  assign bad_op    = !IS_SUPPORTED_OP(op);
  assign bad_funct = isRType && !IS_SUPPORTED_FUNCT(funct);

endmodule

// File: rtl/insn_encoder_loader.sv
// Streams field bundles into instruction memory: range check at start, one
// packed word per accepted bundle, sticky error on unsupported encodings.
module insn_encoder_loader
  import insn_encoder_loader_pkg::*;
#(
  parameter int INSN_ADDR_WIDTH = 10,
  parameter int LEN_WIDTH       = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [INSN_ADDR_WIDTH-1:0] base,
  input  logic [LEN_WIDTH-1:0]       len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [5:0]                 in_op,
  input  logic [4:0]                 in_rs,
  input  logic [4:0]                 in_rt,
  input  logic [4:0]                 in_rd,
  input  logic [3:0]                 in_shamt,
  input  logic [5:0]                 in_funct,
  input  logic [15:0]                in_const,
  output logic                       imem_we,
  output logic [INSN_ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]                imem_wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [INSN_ADDR_WIDTH-1:0] err_addr
);

  localparam int SUM_W = ((INSN_ADDR_WIDTH > LEN_WIDTH + 2) ? INSN_ADDR_WIDTH : LEN_WIDTH + 2) + 1;

  LoadState                   state_reg, state_next;
  logic [INSN_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [LEN_WIDTH-1:0]       remaining_reg, remaining_next;
  logic                       we_reg, we_next;
  logic [INSN_ADDR_WIDTH-1:0] wrAddr_reg, wrAddr_next;
  logic [31:0]                wrData_reg, wrData_next;
  LoadErrCode                 errCode_reg, errCode_next;
  logic [INSN_ADDR_WIDTH-1:0] errAddr_reg, errAddr_next;

  logic [31:0] packedWord;
  logic        badOp;
  logic        badFunct;

  insn_packer packer (
    .op       (in_op),
    .rs       (in_rs),
    .rt       (in_rt),
    .rd       (in_rd),
    .shamt    (in_shamt),
    .funct    (in_funct),
    .constVal (in_const),
    .word     (packedWord),
    .bad_op   (badOp),
    .bad_funct(badFunct)
  );

  // Sum is wide enough that base + 4*len can never wrap before the compare.
  logic [SUM_W-1:0] loadEnd;
  logic             badRange;
  assign loadEnd  = SUM_W'(base) + (SUM_W'(len) << 2);
  assign badRange = (base[1:0] != 2'b00) || (loadEnd > (SUM_W'(1) << INSN_ADDR_WIDTH));

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    we_next        = 1'b0;
    wrAddr_next    = wrAddr_reg;
    wrData_next    = wrData_reg;
    errCode_next   = errCode_reg;
    errAddr_next   = errAddr_reg;

    case (state_reg)
      ST_RUN: begin
        if (in_valid) begin
          if (badOp) begin
            state_next   = ST_ERR;
            errCode_next = LOAD_ERR_OP;
            errAddr_next = addr_reg;
          end else if (badFunct) begin
            state_next   = ST_ERR;
            errCode_next = LOAD_ERR_FUNCT;
            errAddr_next = addr_reg;
          end else begin
            we_next        = 1'b1;
            wrAddr_next    = addr_reg;
            wrData_next    = packedWord;
            addr_next      = addr_reg + INSN_ADDR_WIDTH'(4);
            remaining_next = remaining_reg - LEN_WIDTH'(1);
            if (remaining_reg == LEN_WIDTH'(1)) begin
              state_next = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        state_next = ST_DONE;
      end
      default: begin
        if (start) begin
          errCode_next = LOAD_ERR_NONE;
          errAddr_next = '0;
          if (badRange) begin
            state_next   = ST_ERR;
            errCode_next = LOAD_ERR_RANGE;
            errAddr_next = base;
          end else if (len == '0) begin
            state_next = ST_DONE;
          end else begin
            state_next     = ST_RUN;
            addr_next      = base;
            remaining_next = len;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      we_reg        <= 1'b0;
      wrAddr_reg    <= '0;
      wrData_reg    <= '0;
      errCode_reg   <= LOAD_ERR_NONE;
      errAddr_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      we_reg        <= we_next;
      wrAddr_reg    <= wrAddr_next;
      wrData_reg    <= wrData_next;
      errCode_reg   <= errCode_next;
      errAddr_reg   <= errAddr_next;
    end
  end

  assign in_ready   = (state_reg == ST_RUN);
  assign imem_we    = we_reg;
  assign imem_addr  = wrAddr_reg;
  assign imem_wdata = wrData_reg;
  assign busy       = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign done       = (state_reg == ST_DONE);
  assign err        = (state_reg == ST_ERR);
  assign err_code   = errCode_reg;
  assign err_addr   = errAddr_reg;

endmodule
